max_pool_2x2: RTL and testbench

//  Streaming 2x2/stride-2 max-pooling stage directly downstream of the ReLU stage.

---
 rtl/max_pool_2x2.sv | 124 ++++++++++++
 tb/tb_max_pool_2x2.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
// 2x2/stride-2 max pool over a marker-framed unsigned pixel stream, using a one-line buffer of pair maxima.
// Output is registered 1 clk after the 4th window pixel; there is no backpressure, and valid_i gaps only stretch timing.
module max_pool_2x2 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  err_o
);

  localparam int CW  = $clog2(IMG_WIDTH + 1);
  localparam int RW  = $clog2(IMG_HEIGHT + 1);
  localparam int LBN = IMG_WIDTH / 2;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ROW_EVEN = 2'd1;
  localparam logic [1:0] ROW_ODD  = 2'd2;

  logic [1:0]            state, state_nxt, st_cur;
  logic [CW-1:0]         col, col_nxt, col_cur;
  logic [RW-1:0]         row, row_nxt, row_cur;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] linebuf [LBN];
  logic [LBW-1:0]        lb_idx;
  logic [DATA_WIDTH-1:0] lb_rd, pair_max, quad_max;
  logic                  line_end, active, in_range, odd_col, take, emit, lb_wr;
  logic                  lone_eop, overrun, mid_sop, odd_eof, err_nxt;

  always_comb begin
    // sof_i realigns the frame from any state, so it overrides the registered position.
    st_cur   = sof_i ? ROW_EVEN : state;
    col_cur  = (sop_i || sof_i) ? '0 : col;
    row_cur  = sof_i ? '0 : row;
    line_end = eop_i || eof_i;
    active   = valid_i && (st_cur != IDLE);
    in_range = (col_cur < CW'(IMG_WIDTH));
    odd_col  = col_cur[0];
    lb_idx   = col_cur[LBW:1];
    lb_rd    = linebuf[lb_idx];
    pair_max = (data_i > hold) ? data_i : hold;
    quad_max = (lb_rd > pair_max) ? lb_rd : pair_max;

    take     = active && in_range && (odd_col || !line_end);
    emit     = take && odd_col && (st_cur == ROW_ODD);
    lb_wr    = take && odd_col && (st_cur == ROW_EVEN);

    lone_eop = active && in_range && !odd_col && line_end;
    overrun  = active && (col_cur == CW'(IMG_WIDTH - 1)) && !line_end;
    mid_sop  = valid_i && sop_i && !sof_i && (state != IDLE) && (col != '0);
    odd_eof  = active && eof_i && (st_cur == ROW_EVEN);

    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    if (valid_i) begin
      state_nxt = st_cur;
      col_nxt   = col_cur;
      row_nxt   = row_cur;
      if (active) begin
        if (line_end) begin
          col_nxt = '0;
          row_nxt = row_cur + RW'(1);
          if (eof_i) state_nxt = IDLE;
          else       state_nxt = (st_cur == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end else if (in_range) begin
          col_nxt = col_cur + CW'(1);
        end
      end
    end

    // A frame that never reached eof_i leaves the FSM out of IDLE; that is the incomplete-frame case.
    err_nxt = err_o;
    if (valid_i && sof_i) err_nxt = (state != IDLE);
    if (lone_eop || overrun || mid_sop || odd_eof) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      col          <= col_nxt;
      row          <= row_nxt;
      err_o        <= err_nxt;
      if (take && !odd_col) hold <= data_i;
      if (emit) data_o <= quad_max;
      data_valid_o <= emit;
      sop_o        <= emit && (col_cur == CW'(1));
      eop_o        <= emit && line_end;
      sof_o        <= emit && (col_cur == CW'(1)) && (row_cur == RW'(1));
      eof_o        <= emit && eof_i;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_wr) linebuf[lb_idx] <= pair_max;
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2 on a 4x4 frame: it covers timing, valid gaps, unsigned max, framing errors and reset.
module tb_max_pool_2x2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_i;
  logic       valid_i, sop_i, eop_i, sof_i, eof_i;
  logic [7:0] data_o;
  logic       data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] q[$];
  logic        err_seen = 1'b0;
  logic [7:0]  ramp [16];
  logic [7:0]  flat [16];
  logic [7:0]  uns  [16];

  max_pool_2x2 #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .sop_o(sop_o), .eop_o(eop_o),
    .sof_o(sof_o), .eof_o(eof_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid_o) q.push_back({sop_o, eop_o, sof_o, eof_o, data_o});
    if (err_o) err_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] rec(input logic s, input logic e, input logic f, input logic l,
                                      input logic [7:0] d);
    return {s, e, f, l, d};
  endfunction

  task automatic px(input logic [7:0] d, input logic s, input logic e, input logic f, input logic l);
    @(negedge clk);
    valid_i = 1'b1; data_i = d; sop_i = s; eop_i = e; sof_i = f; eof_i = l;
  endtask

  // Idle cycles carry random junk on data and markers, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = 8'($urandom);
      {sop_i, eop_i, sof_i, eof_i} = 4'($urandom);
    end
  endtask

  task automatic send_frame(input logic [7:0] pix [16], input int gap_max);
    for (int p = 0; p < 16; p++) begin
      px(pix[p], (p % 4) == 0, (p % 4) == 3, p == 0, p == 15);
      if (gap_max > 0) idle($urandom_range(1, gap_max));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_i = 1'b0; data_i = 8'h00;
    {sop_i, eop_i, sof_i, eof_i} = 4'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", {data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o});
    end
    reset = 1'b0;
    idle(4);
    n_checks++;
    if ({data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_idle_junk: got %h expected 0", {data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o});
    end
  endtask

  task automatic test_frame_basic();
    logic [12:0] got, exp;
    int qq;
    q.delete();
    for (int p = 0; p <= 16; p++) begin
      @(negedge clk);
      if (p > 0) begin
        qq = p - 1;
        case (qq)
          5:       exp = {1'b1, rec(1, 0, 1, 0, 8'd5)};
          7:       exp = {1'b1, rec(0, 1, 0, 0, 8'd7)};
          13:      exp = {1'b1, rec(1, 0, 0, 0, 8'd13)};
          15:      exp = {1'b1, rec(0, 1, 0, 1, 8'd15)};
          default: exp = 13'h0;
        endcase
        got = {data_valid_o, sop_o, eop_o, sof_o, eof_o, (data_valid_o ? data_o : 8'h00)};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL basic_after_px%0d: got %h expected %h", qq, got, exp);
        end
      end
      if (p < 16) begin
        valid_i = 1'b1; data_i = 8'(p);
        sop_i = (p % 4) == 0; eop_i = (p % 4) == 3; sof_i = p == 0; eof_i = p == 15;
      end else begin
        valid_i = 1'b0;
      end
    end
    idle(2);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: got %b expected 0", err_o);
    end
  endtask

  task automatic test_gaps();
    logic [11:0] exp [4];
    exp = '{rec(1, 0, 1, 0, 8'd5), rec(0, 1, 0, 0, 8'd7), rec(1, 0, 0, 0, 8'd13), rec(0, 1, 0, 1, 8'd15)};
    q.delete();
    send_frame(ramp, 3);
    idle(3);
    n_checks++;
    if (q.size() !== 4) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d expected 4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ((i >= q.size()) || (q[i] !== exp[i])) begin
        n_fail++;
        $display("FAIL gaps_out%0d: got %h expected %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [11:0] exp [4];
    exp = '{rec(1, 0, 1, 0, 8'd255), rec(0, 1, 0, 0, 8'd200), rec(1, 0, 0, 0, 8'd0), rec(0, 1, 0, 1, 8'd129)};
    q.delete();
    send_frame(uns, 0);
    idle(3);
    n_checks++;
    if (q.size() !== 4) begin
      n_fail++;
      $display("FAIL unsigned_count: got %0d expected 4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ((i >= q.size()) || (q[i] !== exp[i])) begin
        n_fail++;
        $display("FAIL unsigned_out%0d: got %h expected %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp [8];
    exp = '{rec(1, 0, 1, 0, 8'd5),  rec(0, 1, 0, 0, 8'd7),  rec(1, 0, 0, 0, 8'd13), rec(0, 1, 0, 1, 8'd15),
            rec(1, 0, 1, 0, 8'h10), rec(0, 1, 0, 0, 8'h10), rec(1, 0, 0, 0, 8'h10), rec(0, 1, 0, 1, 8'h10)};
    q.delete();
    err_seen = 1'b0;
    send_frame(ramp, 0);
    send_frame(flat, 0);
    idle(3);
    n_checks++;
    if (q.size() !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ((i >= q.size()) || (q[i] !== exp[i])) begin
        n_fail++;
        $display("FAIL b2b_out%0d: got %h expected %h", i, q[i], exp[i]);
      end
    end
    n_checks++;
    if (err_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_err: got err_o seen=%b expected 0", err_seen);
    end
  endtask

  task automatic test_short_line();
    logic [11:0] exp [3];
    exp = '{rec(1, 0, 1, 0, 8'd5), rec(1, 0, 0, 0, 8'd13), rec(0, 1, 0, 1, 8'd15)};
    q.delete();
    for (int p = 0; p < 4; p++) px(8'(p), p == 0, p == 3, p == 0, 1'b0);
    px(8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    px(8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL short_err_set: got %b expected 1", err_o);
    end
    for (int p = 8; p < 16; p++) px(8'(p), (p % 4) == 0, (p % 4) == 3, 1'b0, p == 15);
    idle(3);
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL short_err_sticky: got %b expected 1", err_o);
    end
    n_checks++;
    if (q.size() !== 3) begin
      n_fail++;
      $display("FAIL short_count: got %0d expected 3", q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ((i >= q.size()) || (q[i] !== exp[i])) begin
        n_fail++;
        $display("FAIL short_out%0d: got %h expected %h", i, q[i], exp[i]);
      end
    end
    q.delete();
    px(8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL short_err_clear: got %b expected 0", err_o);
    end
    for (int p = 1; p < 16; p++) px(8'(p), (p % 4) == 0, (p % 4) == 3, 1'b0, p == 15);
    idle(3);
    n_checks++;
    if ((q.size() !== 4) || (err_o !== 1'b0)) begin
      n_fail++;
      $display("FAIL short_recover: got count=%0d err=%b expected count=4 err=0", q.size(), err_o);
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    for (int p = 0; p < 6; p++) px(8'(p), (p % 4) == 0, (p % 4) == 3, p == 0, 1'b0);
    idle(1);
    n_checks++;
    if ({data_valid_o, data_o} !== {1'b1, 8'd5}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %h expected 105", {data_valid_o, data_o});
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o} !== 14'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected 0", {data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o});
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    for (int p = 6; p < 16; p++) px(8'(p), (p % 4) == 0, (p % 4) == 3, 1'b0, p == 15);
    idle(3);
    n_checks++;
    if ((q.size() !== 0) || (err_o !== 1'b0)) begin
      n_fail++;
      $display("FAIL rstmid_drop: got count=%0d err=%b expected count=0 err=0", q.size(), err_o);
    end
    send_frame(ramp, 0);
    idle(3);
    n_checks++;
    if ((q.size() !== 4) || (q[0] !== rec(1, 0, 1, 0, 8'd5)) || (q[3] !== rec(0, 1, 0, 1, 8'd15))) begin
      n_fail++;
      $display("FAIL rstmid_recover: got count=%0d first=%h last=%h expected 4 %h %h",
               q.size(), q[0], q[3], rec(1, 0, 1, 0, 8'd5), rec(0, 1, 0, 1, 8'd15));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[i] = 8'(i);
      flat[i] = 8'h10;
    end
    uns = '{8'd255, 8'd0,   8'd128, 8'd127,
            8'd0,   8'd254, 8'd1,   8'd200,
            8'd0,   8'd0,   8'd128, 8'd127,
            8'd0,   8'd0,   8'd129, 8'd0};
    test_reset();
    test_frame_basic();
    test_gaps();
    test_unsigned();
    test_back_to_back();
    test_short_line();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
